i2c_slave_regif: RTL and testbench

- I2C target (slave) that consumes the SCL/iSDA master stimulus and bridges it to a byte-wide register-port interface.
- Oversamples SCL/SDA on the system clock and decodes START/STOP and 7-bit addressing with ACK.
- Each transaction is: address + R/W byte, then a register-address byte, then either one received write byte (W) or transmitted read bytes (R).
- Sits between the bus pins and the on-chip register bank.

---
 rtl/i2c_slave_regif.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// I2C target bridging a 7-bit-addressed bus to a byte-wide register port.
// Each transaction is: address+R/W, register byte, then one write byte or a read burst.
`timescale 1ns/1ps
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ID    = 7'b0000101,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       SCL,
  input  logic       iSDA,
  output logic       oSDA,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       id_err
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] cnt, cnt_n;
  logic [7:0] rx_shift, rx_shift_n, tx_shift, tx_shift_n, rx_byte;
  logic       rw, rw_n, phase, phase_n, load_pend;
  logic       osda_n, reg_we_n, reg_re_n, busy_n, id_err_n;
  logic [7:0] reg_addr_n, reg_wdata_n;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // Requiring SCL high on both samples keeps START/STOP disjoint from SCL edges.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {rx_shift[6:0], sda_s};

  // NOTE: every register here updates with <= so all flops see the same pre-edge values.
  always_ff @(posedge CLK) begin
    // NOTE: sync flops reset to the idle-bus level (1) so reset itself creates no edge.
    if (Reset) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rw        <= 1'b0;
      phase     <= 1'b0;
      load_pend <= 1'b0;
      oSDA      <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], iSDA};
      scl_d     <= scl_s;
      sda_d     <= sda_s;
      state     <= state_n;
      cnt       <= cnt_n;
      rx_shift  <= rx_shift_n;
      tx_shift  <= tx_shift_n;
      rw        <= rw_n;
      phase     <= phase_n;
      load_pend <= reg_re;
      oSDA      <= osda_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_we    <= reg_we_n;
      reg_re    <= reg_re_n;
      busy      <= busy_n;
      id_err    <= id_err_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    rx_shift_n  = rx_shift;
    tx_shift_n  = load_pend ? reg_rdata : tx_shift;
    rw_n        = rw;
    phase_n     = phase;
    osda_n      = oSDA;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    reg_we_n    = 1'b0;
    reg_re_n    = 1'b0;
    busy_n      = busy;
    id_err_n    = id_err;

    // phase marks the second half of an ACK slot (ACK being driven or read burst pending).
    unique case (state)
      IDLE, WAIT_STOP: ;
      ADDR, REG, WDATA: begin
        if (scl_rise) begin
          rx_shift_n = rx_byte;
          cnt_n      = cnt + 3'd1;
          if (cnt == 3'd7) begin
            phase_n = 1'b0;
            unique case (state)
              ADDR: begin
                rw_n    = sda_s;
                state_n = ADDR_ACK;
              end
              REG: begin
                reg_addr_n = rx_byte;
                reg_re_n   = rw;
                state_n    = REG_ACK;
              end
              default: state_n = WDATA_ACK;
            endcase
          end
        end
      end
      ADDR_ACK: begin
        if (scl_fall) begin
          if (phase) begin
            osda_n  = 1'b1;
            phase_n = 1'b0;
            state_n = REG;
          end else if (rx_shift[7:1] == SLAVE_ID) begin
            osda_n  = 1'b0;
            busy_n  = 1'b1;
            phase_n = 1'b1;
          end else begin
            id_err_n = 1'b1;
            busy_n   = 1'b0;
            state_n  = WAIT_STOP;
          end
        end
      end
      REG_ACK: begin
        if (scl_fall) begin
          if (!phase) begin
            osda_n  = 1'b0;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            cnt_n   = '0;
            if (rw) begin
              osda_n     = tx_shift[7];
              tx_shift_n = {tx_shift[6:0], 1'b0};
              state_n    = RDATA;
            end else begin
              osda_n  = 1'b1;
              state_n = WDATA;
            end
          end
        end
      end
      WDATA_ACK: begin
        if (scl_fall) begin
          if (!phase) begin
            osda_n      = 1'b0;
            reg_we_n    = 1'b1;
            reg_wdata_n = rx_shift;
            phase_n     = 1'b1;
          end else begin
            osda_n  = 1'b1;
            phase_n = 1'b0;
            busy_n  = 1'b0;
            state_n = WAIT_STOP;
          end
        end
      end
      RDATA: begin
        if (scl_fall) begin
          if (cnt == 3'd7) begin
            osda_n  = 1'b1;
            cnt_n   = '0;
            phase_n = 1'b0;
            state_n = RDATA_ACK;
          end else begin
            osda_n     = tx_shift[7];
            tx_shift_n = {tx_shift[6:0], 1'b0};
            cnt_n      = cnt + 3'd1;
          end
        end
      end
      RDATA_ACK: begin
        if (!phase && scl_rise) begin
          if (!sda_s) begin
            reg_addr_n = reg_addr + 8'd1;
            reg_re_n   = 1'b1;
            phase_n    = 1'b1;
          end else begin
            busy_n  = 1'b0;
            state_n = WAIT_STOP;
          end
        end else if (phase && scl_fall) begin
          osda_n     = tx_shift[7];
          tx_shift_n = {tx_shift[6:0], 1'b0};
          cnt_n      = '0;
          phase_n    = 1'b0;
          state_n    = RDATA;
        end
      end
      default: state_n = IDLE;
    endcase

    if (stop_det) begin
      state_n  = IDLE;
      cnt_n    = '0;
      phase_n  = 1'b0;
      osda_n   = 1'b1;
      busy_n   = 1'b0;
      reg_we_n = 1'b0;
      reg_re_n = 1'b0;
    end else if (start_det) begin
      state_n  = ADDR;
      cnt_n    = '0;
      phase_n  = 1'b0;
      osda_n   = 1'b1;
      reg_we_n = 1'b0;
      reg_re_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bit-banged I2C master driving i2c_slave_regif, with a register-bank responder
// and an expected-memory model built from the bus transactions the bench issues.
`timescale 1ns/1ps
module tb_i2c_slave_regif;

  localparam logic [6:0] ID = 7'b0000101;
  localparam int Q = 60;  // quarter of an SCL bit period, in ns

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       SCL = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       oSDA;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, id_err;

  logic [7:0]  bank    [256];
  logic [7:0]  exp_mem [256];
  logic [15:0] we_q [$];
  logic [7:0]  re_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  assign sda_line = sda_m & oSDA;

  i2c_slave_regif #(.SLAVE_ID(ID), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .Reset(Reset), .SCL(SCL), .iSDA(sda_line), .oSDA(oSDA),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .id_err(id_err)
  );

  always #5 CLK = ~CLK;

  // Register bank: answers reads one cycle after reg_re, absorbs writes.
  initial reg_rdata = 8'h00;
  always @(negedge CLK) begin
    if (reg_re) begin
      reg_rdata = bank[reg_addr];
      re_q.push_back(reg_addr);
    end
    if (reg_we) begin
      bank[reg_addr] = reg_wdata;
      we_q.push_back({reg_addr, reg_wdata});
    end
    if (reg_we || reg_re) begin
      n_cmp++;
      if (reg_we && reg_re) begin
        n_bad++;
        $display("FAIL strobe_overlap: reg_we=%b reg_re=%b, required not both high", reg_we, reg_re);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit of 2000000 ns", $time);
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    SCL = 1'b1; #(2*Q);
    SCL = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    SCL = 1'b1; #Q;
    b = sda_line; #Q;
    SCL = 1'b0; #Q;
  endtask

  task automatic do_start();
    sda_m = 1'b1; #Q;
    SCL = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    SCL = 1'b0; #Q;
  endtask

  task automatic do_stop();
    sda_m = 1'b0; #Q;
    SCL = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [7:0] v;
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      v[i] = bit_v;
    end
    b = v;
  endtask

  task automatic test_reset();
    Reset = 1'b1; #30; Reset = 1'b0; #10;
    n_cmp++;
    if ({oSDA, reg_addr, reg_wdata, reg_we, reg_re, busy, id_err} !== {1'b1, 8'h00, 8'h00, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_state: oSDA=%b addr=%h wdata=%h we=%b re=%b busy=%b id_err=%b, required 1 00 00 0 0 0 0",
               oSDA, reg_addr, reg_wdata, reg_we, reg_re, busy, id_err);
    end
  endtask

  task automatic test_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic ack;
    we_q.delete(); re_q.delete();
    do_start();
    write_byte({ID, 1'b0}, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s addr_ack: got %b want 0", tag, ack); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_set: got %b want 1", tag, busy); end
    write_byte(a, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s reg_ack: got %b want 0", tag, ack); end
    write_byte(d, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s data_ack: got %b want 0", tag, ack); end
    do_stop();
    exp_mem[a] = d;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_clear: got %b want 0", tag, busy); end
    n_cmp++;
    if (we_q.size() != 1) begin
      n_bad++; $display("FAIL %s we_count: got %0d want 1", tag, we_q.size());
    end else if (we_q[0] !== {a, d}) begin
      n_bad++; $display("FAIL %s we_addr_data: got %h want %h", tag, we_q[0], {a, d});
    end
    n_cmp++; if (re_q.size() != 0) begin n_bad++; $display("FAIL %s re_count: got %0d want 0", tag, re_q.size()); end
  endtask

  task automatic test_read(input logic [7:0] a, input int n, input string tag);
    logic ack;
    logic [7:0] b, ea;
    re_q.delete(); we_q.delete();
    do_start();
    write_byte({ID, 1'b1}, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s addr_ack: got %b want 0", tag, ack); end
    write_byte(a, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s reg_ack: got %b want 0", tag, ack); end
    for (int i = 0; i < n; i++) begin
      ea = a + 8'(i);
      read_byte(b);
      n_cmp++;
      if (b !== exp_mem[ea]) begin
        n_bad++; $display("FAIL %s rdata[%0d]: got %h want %h", tag, i, b, exp_mem[ea]);
      end
      send_bit(i == n - 1);
    end
    n_cmp++;
    if ({oSDA, busy} !== 2'b10) begin
      n_bad++; $display("FAIL %s after_nack: oSDA=%b busy=%b want 1 0", tag, oSDA, busy);
    end
    do_stop();
    n_cmp++;
    if (re_q.size() != n) begin
      n_bad++; $display("FAIL %s re_count: got %0d want %0d", tag, re_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ea = a + 8'(i);
        n_cmp++;
        if (re_q[i] !== ea) begin
          n_bad++; $display("FAIL %s re_addr[%0d]: got %h want %h", tag, i, re_q[i], ea);
        end
      end
    end
    n_cmp++; if (we_q.size() != 0) begin n_bad++; $display("FAIL %s we_count: got %0d want 0", tag, we_q.size()); end
  endtask

  task automatic test_wrong_id();
    logic ack;
    we_q.delete(); re_q.delete();
    do_start();
    write_byte(8'hAA, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wrong_id ack_slot: got %b want 1", ack); end
    n_cmp++;
    if ({id_err, busy} !== 2'b10) begin
      n_bad++; $display("FAIL wrong_id flags: id_err=%b busy=%b want 1 0", id_err, busy);
    end
    write_byte(8'($urandom), ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wrong_id ignored_byte_ack: got %b want 1", ack); end
    do_stop();
    n_cmp++;
    if (we_q.size() + re_q.size() != 0) begin
      n_bad++; $display("FAIL wrong_id strobes: got we=%0d re=%0d want 0 0", we_q.size(), re_q.size());
    end
    n_cmp++; if (id_err !== 1'b1) begin n_bad++; $display("FAIL wrong_id sticky: got %b want 1", id_err); end
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] a, d;
    we_q.delete(); re_q.delete();
    a = 8'($urandom);
    do_start();
    write_byte({ID, 1'b0}, ack);
    write_byte(a, ack);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    n_cmp++; if (we_q.size() != 0) begin n_bad++; $display("FAIL rstart no_we: got %0d want 0", we_q.size()); end
    d = 8'($urandom);
    test_write(a ^ 8'h5A, d, "rstart_write");
  endtask

  task automatic test_reset_mid();
    logic ack;
    we_q.delete(); re_q.delete();
    do_start();
    write_byte({ID, 1'b0}, ack);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_mid busy_before: got %b want 1", busy); end
    Reset = 1'b1; #10; Reset = 1'b0;
    n_cmp++;
    if ({oSDA, reg_we, reg_re, busy, id_err} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_mid state: oSDA=%b we=%b re=%b busy=%b id_err=%b want 1 0 0 0 0",
                        oSDA, reg_we, reg_re, busy, id_err);
    end
    do_stop();
    n_cmp++; if (we_q.size() != 0) begin n_bad++; $display("FAIL reset_mid no_we: got %0d want 0", we_q.size()); end
    test_write(8'($urandom), 8'($urandom), "reset_mid_write");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bank[i]    = 8'($urandom);
      exp_mem[i] = bank[i];
    end
    bank[8'hB5] = 8'h3C; exp_mem[8'hB5] = 8'h3C;

    test_reset();
    test_wrong_id();
    test_read(8'hB5, 1, "read_b5");
    test_write(8'h4A, 8'h4A, "write_4a");
    test_read(8'h4A, 1, "readback_4a");
    test_read(8'hFF, 2, "burst_wrap");
    test_repeated_start();
    test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a, d;
      a = 8'($urandom);
      d = 8'($urandom);
      test_write(a, d, "rand_write");
      test_read(a, 1 + int'($urandom_range(0, 2)), "rand_read");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
